// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one memory between the fetch and data ports with a fixed number of wait states.
// Build option MEM_ARB_RR_EN swaps fixed data-first priority for round-robin between the two ports.
module mem_arbiter #(
  parameter int unsigned LATENCY = 2,
  parameter int unsigned CW      = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        if_req,
  input  logic [15:0] if_addr,
  output logic [15:0] if_rdata,
  output logic        if_done,
  input  logic        dm_req,
  input  logic        dm_wr,
  input  logic [15:0] dm_addr,
  input  logic [15:0] dm_wdata,
  output logic [15:0] dm_rdata,
  output logic        dm_done,
  output logic        mem_enable,
  output logic        mem_wr,
  output logic [15:0] mem_addr,
  output logic [15:0] mem_data_in,
  input  logic [15:0] mem_data_out,
  output logic        stall,
  output logic        err
);

  localparam int unsigned AW = 16;
  localparam int unsigned DW = 16;

  typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

  typedef struct packed {
    logic          owner_dm;
    logic          wr;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
  } cmd_t;

  state_t        state, state_nxt;
  cmd_t          cmd, cmd_nxt;
  logic [CW-1:0] cnt, cnt_nxt;
  logic          err_set;
  logic          grant_dm;
  logic          last_beat;

`ifdef MEM_ARB_RR_EN
  // 1 when the data port received the most recent grant
  logic last_dm;

  assign grant_dm = dm_req & (~if_req | ~last_dm);

  always_ff @(posedge clk) begin
    if (rst) begin
      last_dm <= 1'b0;
    end else if (state == IDLE && (if_req || dm_req)) begin
      last_dm <= grant_dm;
    end
  end
`else
  assign grant_dm = dm_req;
`endif

  assign last_beat = (state == ACCESS) && (cnt == '0);

  // Next-state and command latch
  always_comb begin
    state_nxt = state;
    cmd_nxt   = cmd;
    cnt_nxt   = cnt;
    err_set   = 1'b0;
    case (state)
      IDLE: begin
        if (if_req || dm_req) begin
          cmd_nxt.owner_dm = grant_dm;
          cmd_nxt.wr       = grant_dm & dm_wr;
          cmd_nxt.addr     = grant_dm ? dm_addr : if_addr;
          cmd_nxt.wdata    = grant_dm ? dm_wdata : '0;
          cnt_nxt          = CW'(LATENCY - 1);
          err_set          = grant_dm ? dm_addr[0] : if_addr[0];
          state_nxt        = ACCESS;
        end
      end
      ACCESS: begin
        cnt_nxt = cnt - CW'(1);
        if (cmd.owner_dm ? ~dm_req : ~if_req) begin
          err_set = 1'b1;
        end
        if (cnt == '0) begin
          cnt_nxt   = '0;
          state_nxt = RESP;
        end
      end
      RESP: begin
        state_nxt = IDLE;
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      cmd      <= '0;
      cnt      <= '0;
      if_rdata <= '0;
      dm_rdata <= '0;
      err      <= 1'b0;
    end else begin
      state <= state_nxt;
      cmd   <= cmd_nxt;
      cnt   <= cnt_nxt;
      if (err_set) begin
        err <= 1'b1;
      end
      if (last_beat && !cmd.wr) begin
        if (cmd.owner_dm) begin
          dm_rdata <= mem_data_out;
        end else begin
          if_rdata <= mem_data_out;
        end
      end
    end
  end

  // Memory side is quiet outside ACCESS; rst suppresses a coinciding write strobe
  assign mem_enable  = (state == ACCESS);
  assign mem_wr      = last_beat & cmd.wr & ~rst;
  assign mem_addr    = mem_enable ? cmd.addr : '0;
  assign mem_data_in = mem_enable ? cmd.wdata : '0;

  assign if_done = (state == RESP) & ~cmd.owner_dm;
  assign dm_done = (state == RESP) & cmd.owner_dm;
  assign stall   = (if_req & ~if_done) | (dm_req & ~dm_done);

endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: directed self-checking bench for mem_arbiter at LATENCY=2.
module tb_mem_arbiter;

  localparam int unsigned LATENCY = 2;
  localparam int unsigned CW      = 4;

`ifdef MEM_ARB_RR_EN
  localparam bit RR = 1'b1;
`else
  localparam bit RR = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        if_req = 1'b0;
  logic [15:0] if_addr = '0;
  logic [15:0] if_rdata;
  logic        if_done;
  logic        dm_req = 1'b0;
  logic        dm_wr = 1'b0;
  logic [15:0] dm_addr = '0;
  logic [15:0] dm_wdata = '0;
  logic [15:0] dm_rdata;
  logic        dm_done;
  logic        mem_enable;
  logic        mem_wr;
  logic [15:0] mem_addr;
  logic [15:0] mem_data_in;
  logic [15:0] mem_data_out = '0;
  logic        stall;
  logic        err;

  int n_checks = 0;
  int n_fail   = 0;

  mem_arbiter #(.LATENCY(LATENCY), .CW(CW)) dut (
    .clk(clk), .rst(rst),
    .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata), .if_done(if_done),
    .dm_req(dm_req), .dm_wr(dm_wr), .dm_addr(dm_addr), .dm_wdata(dm_wdata),
    .dm_rdata(dm_rdata), .dm_done(dm_done),
    .mem_enable(mem_enable), .mem_wr(mem_wr), .mem_addr(mem_addr),
    .mem_data_in(mem_data_in), .mem_data_out(mem_data_out),
    .stall(stall), .err(err)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%04h expected 0x%04h at %0t", tag, got, exp, $time);
    end
  endtask

  // Advance to just after the next rising edge (start of the next cycle)
  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic skip(input int n);
    for (int i = 0; i < n; i++) next_cycle();
  endtask

  // Sample point mid-cycle, away from the active edge
  task automatic sample();
    @(negedge clk);
  endtask

  task automatic clear_inputs();
    if_req   = 1'b0;
    if_addr  = '0;
    dm_req   = 1'b0;
    dm_wr    = 1'b0;
    dm_addr  = '0;
    dm_wdata = '0;
  endtask

  task automatic do_reset();
    clear_inputs();
    rst = 1'b1;
    next_cycle();
    rst = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    next_cycle();
    rst = 1'b0;
    sample();
    check("rst_state_enable", 16'(mem_enable), 16'h0);
    check("rst_state_wr",     16'(mem_wr), 16'h0);
    check("rst_state_done",   16'({if_done, dm_done}), 16'h0);
    check("rst_state_err",    16'(err), 16'h0);
    check("rst_state_stall",  16'(stall), 16'h0);
    check("rst_if_rdata",     if_rdata, 16'h0000);

    // Fetch only
    next_cycle();
    if_req = 1'b1; if_addr = 16'h0010; mem_data_out = 16'hABCD;
    sample();
    check("t1_c0_stall",  16'(stall), 16'h1);
    check("t1_c0_enable", 16'(mem_enable), 16'h0);
    next_cycle(); sample();
    check("t1_c1_enable", 16'(mem_enable), 16'h1);
    check("t1_c1_addr",   mem_addr, 16'h0010);
    check("t1_c1_stall",  16'(stall), 16'h1);
    next_cycle(); sample();
    check("t1_c2_enable", 16'(mem_enable), 16'h1);
    check("t1_c2_addr",   mem_addr, 16'h0010);
    check("t1_c2_done",   16'(if_done), 16'h0);
    check("t1_c2_wr",     16'(mem_wr), 16'h0);
    next_cycle(); sample();
    check("t1_c3_done",   16'(if_done), 16'h1);
    check("t1_c3_rdata",  if_rdata, 16'hABCD);
    check("t1_c3_stall",  16'(stall), 16'h0);
    check("t1_c3_enable", 16'(mem_enable), 16'h0);
    if_req = 1'b0;
    next_cycle(); sample();
    check("t1_c4_done",   16'(if_done), 16'h0);
    check("t1_c4_enable", 16'(mem_enable), 16'h0);

    // Data write
    next_cycle();
    dm_req = 1'b1; dm_wr = 1'b1; dm_addr = 16'h0200; dm_wdata = 16'h1234; mem_data_out = 16'h5555;
    sample();
    check("t2_c0_wr", 16'(mem_wr), 16'h0);
    next_cycle(); sample();
    check("t2_c1_wr",     16'(mem_wr), 16'h0);
    check("t2_c1_wdata",  mem_data_in, 16'h1234);
    next_cycle(); sample();
    check("t2_c2_wr",     16'(mem_wr), 16'h1);
    check("t2_c2_addr",   mem_addr, 16'h0200);
    check("t2_c2_wdata",  mem_data_in, 16'h1234);
    next_cycle(); sample();
    check("t2_c3_wr",     16'(mem_wr), 16'h0);
    check("t2_c3_done",   16'(dm_done), 16'h1);
    check("t2_c3_dm_rdata_hold", dm_rdata, 16'h0000);
    check("t2_c3_if_rdata_hold", if_rdata, 16'hABCD);
    clear_inputs();
    next_cycle(); sample();
    check("t2_c4_done", 16'(dm_done), 16'h0);

    // Both request together, data port wins from reset in both builds
    do_reset();
    if_req = 1'b1; if_addr = 16'h0020;
    dm_req = 1'b1; dm_wr = 1'b0; dm_addr = 16'h0300; mem_data_out = 16'h7777;
    next_cycle(); sample();
    check("t3_c1_addr", mem_addr, 16'h0300);
    next_cycle(); next_cycle(); sample();
    check("t3_c3_dm_done", 16'(dm_done), 16'h1);
    check("t3_c3_if_done", 16'(if_done), 16'h0);
    check("t3_c3_dm_rdata", dm_rdata, 16'h7777);
    check("t3_c3_stall", 16'(stall), 16'h1);
    dm_req = 1'b0; mem_data_out = 16'h8888;
    next_cycle(); sample();
    check("t3_c4_enable", 16'(mem_enable), 16'h0);
    next_cycle(); sample();
    check("t3_c5_addr", mem_addr, 16'h0020);
    next_cycle(); sample();
    check("t3_c6_if_done", 16'(if_done), 16'h0);
    next_cycle(); sample();
    check("t3_c7_if_done", 16'(if_done), 16'h1);
    check("t3_c7_if_rdata", if_rdata, 16'h8888);
    check("t3_c7_dm_rdata_hold", dm_rdata, 16'h7777);
    if_req = 1'b0;
    next_cycle();

    // Both held continuously: fixed priority keeps data, round-robin alternates
    if_req = 1'b1; if_addr = 16'h0040;
    dm_req = 1'b1; dm_wr = 1'b0; dm_addr = 16'h0080;
    for (int k = 0; k < 4; k++) begin
      skip(3); sample();
      check($sformatf("t3_cont_dm_done_%0d", k), 16'(dm_done), RR ? 16'((k % 2) == 0) : 16'h1);
      check($sformatf("t3_cont_if_done_%0d", k), 16'(if_done), RR ? 16'((k % 2) == 1) : 16'h0);
      if (k < 3) next_cycle();
    end
    clear_inputs();
    next_cycle(); sample();
    check("t3_cont_err", 16'(err), 16'h0);

    // Reset lands on the final cycle of a write
    next_cycle();
    dm_req = 1'b1; dm_wr = 1'b1; dm_addr = 16'h0400; dm_wdata = 16'hBEEF;
    next_cycle(); sample();
    check("t4_c1_wr", 16'(mem_wr), 16'h0);
    next_cycle();
    rst = 1'b1; dm_req = 1'b0;
    sample();
    check("t4_c2_wr_suppressed", 16'(mem_wr), 16'h0);
    next_cycle();
    rst = 1'b0;
    sample();
    check("t4_c3_dm_done",  16'(dm_done), 16'h0);
    check("t4_c3_enable",   16'(mem_enable), 16'h0);
    check("t4_c3_wr",       16'(mem_wr), 16'h0);
    check("t4_c3_addr",     mem_addr, 16'h0000);
    check("t4_c3_wdata",    mem_data_in, 16'h0000);
    check("t4_c3_err",      16'(err), 16'h0);
    check("t4_c3_stall",    16'(stall), 16'h0);
    check("t4_c3_dm_rdata", dm_rdata, 16'h0000);
    check("t4_c3_if_rdata", if_rdata, 16'h0000);
    next_cycle();
    dm_req = 1'b1; dm_wr = 1'b0; dm_addr = 16'h0500; mem_data_out = 16'h4321;
    skip(3); sample();
    check("t4_next_done",  16'(dm_done), 16'h1);
    check("t4_next_rdata", dm_rdata, 16'h4321);
    dm_req = 1'b0;
    next_cycle();

    // Owner drops req mid-access
    dm_req = 1'b1; dm_wr = 1'b0; dm_addr = 16'h0600; mem_data_out = 16'h0F0F;
    next_cycle();
    dm_req = 1'b0;
    sample();
    check("t5_c1_err", 16'(err), 16'h0);
    next_cycle(); sample();
    check("t5_c2_err", 16'(err), 16'h1);
    next_cycle(); sample();
    check("t5_c3_done", 16'(dm_done), 16'h1);
    check("t5_c3_err",  16'(err), 16'h1);
    next_cycle(); sample();
    check("t5_c4_err_sticky", 16'(err), 16'h1);
    do_reset();
    sample();
    check("t5_err_cleared", 16'(err), 16'h0);

    // Misaligned fetch address
    next_cycle();
    if_req = 1'b1; if_addr = 16'h0003;
    next_cycle(); sample();
    check("t5_odd_addr",  mem_addr, 16'h0003);
    check("t5_odd_err",   16'(err), 16'h1);
    next_cycle(); next_cycle(); sample();
    check("t5_odd_done",  16'(if_done), 16'h1);
    if_req = 1'b0;
    next_cycle(); sample();
    check("t5_odd_err_sticky", 16'(err), 16'h1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
- Sequences a single shared memory between the instruction-fetch port and the data-memory port of the processor datapath.
- Turns each port's request into a multi-cycle memory access with a fixed number of wait states, set by LATENCY.
- Returns read data and a one-cycle done pulse to the owning port.
- Drives a global stall and a sticky err bit, which the processor ORs into its top-level err.

Parameters:
- LATENCY, 2: cycles each access holds the memory (legal range 1..15).
- CW, 4: width of the wait-state counter; must satisfy 2^CW > LATENCY.

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous active-high reset
- if_req  in  1  fetch request; held until if_done
- if_addr  in  16  fetch address (word-aligned)
- if_rdata  out  16  fetch read data; valid while if_done=1
- if_done  out  1  one-cycle completion pulse for fetch
- dm_req  in  1  data request; held until dm_done
- dm_wr  in  1  1=write, 0=read
- dm_addr  in  16  data address (word-aligned)
- dm_wdata  in  16  write data
- dm_rdata  out  16  data read data; valid while dm_done=1
- dm_done  out  1  one-cycle completion pulse for data
- mem_enable  out  1  memory enable
- mem_wr  out  1  memory write strobe
- mem_addr  out  16  memory address
- mem_data_in  out  16  write data to memory
- mem_data_out  in  16  read data from memory (combinational read)
- stall  out  1  processor stall
- err  out  1  sticky protocol error

Behaviour:
- Clocking and reset: one clock; reset is synchronous and active-high. Ports are named clk and rst.
- Reset values: on a clk edge with rst=1, all of the following clear to 0 by the next cycle: state=IDLE, counter, latched command, rdata registers, all done/mem_* outputs, err.
- States: IDLE, ACCESS, RESP.
- IDLE:
  - If any request is present, select the winner.
  - Latch the winner's owner id, addr, wr and wdata; fetch is always a read.
  - Load counter=LATENCY-1 and go to ACCESS.
  - No memory activity in this cycle.
- ACCESS:
  - mem_enable=1; mem_addr and mem_data_in come from the latched registers, not live inputs.
  - mem_wr=latched_wr & (counter==0) & ~rst, so exactly one write strobe occurs per write access.
  - The counter decrements each cycle.
  - When counter==0: if the access is a read, capture mem_data_out into the owner's rdata register; then go to RESP.
- RESP:
  - Pulse the owner's done for one cycle; its rdata is valid.
  - Go to IDLE.
  - The requester drops req in this cycle, or may keep it high to request a new access.
- Timing: a request seen in cycle 0 occupies the memory in cycles 1..LATENCY and gets done in cycle LATENCY+1. Occupancy is LATENCY+2 cycles per access.
- rdata registers update only on reads and otherwise hold their value.
- Priority: fixed; dm wins when both request in IDLE. A losing request waits; requests never preempt an access in progress.
- stall = (if_req & ~if_done) | (dm_req & ~dm_done), combinational.
- err is set, and stays set until rst, when either of the following occurs:
  - The owner deasserts req during ACCESS. The access still completes and done still pulses.
  - A request is granted with addr[0]=1. The access proceeds with the address unmodified.
- rst in any state: the access is abandoned with no done pulse. A write whose final ACCESS cycle coincides with rst never asserts mem_wr.
- Unused mem_* outputs are 0 outside ACCESS.

Optional Feature:
- Macro: MEM_ARB_RR_EN.
- Defined: adds a last_owner register, reset to fetch.
  - When both ports request in IDLE, the port not granted most recently wins.
  - last_owner updates on every grant.
- Undefined: fixed data-over-fetch priority; no last_owner register is built.

Test Plan:
1. LATENCY=2, fetch only: if_req=1 and if_addr=0x0010 in cycle 0, memory returns 0xABCD -> mem_enable=1 and mem_addr=0x0010 in cycles 1-2; if_done=1 only in cycle 3 with if_rdata=0xABCD; stall=1 in cycles 0-2 and 0 in cycle 3.
2. Data write: dm_req=1, dm_wr=1, dm_addr=0x0200, dm_wdata=0x1234 -> mem_wr=1 only in cycle 2 with mem_data_in=0x1234; dm_done pulses in cycle 3; dm_rdata unchanged.
3. Both ports request in cycle 0, fixed priority -> dm_done in cycle 3, fetch granted in cycle 4, if_done in cycle 7. With MEM_ARB_RR_EN and both requesting continuously, grants alternate dm, if, dm, if.
4. rst=1 in cycle 2 of a LATENCY=2 write -> mem_wr never asserts; no dm_done; all outputs 0 in cycle 3; the next request is served normally.
5. Owner drops dm_req in cycle 1 -> err=1 from cycle 2 onward, dm_done still pulses in cycle 3, err persists until rst. A separate grant with if_addr=0x0003 also sets err.
